// File: rtl/pov_pkg.sv
// Shared types and default sizes for the POV column reader and its serializer.
package pov_pkg;

    typedef enum logic [1:0] {
        StArm,
        StMeasure,
        StRun,
        StGrant
    } pov_state_e;

    localparam int unsigned COLS_DEF     = 256;
    localparam int unsigned AWIDTH_DEF   = 8;
    localparam int unsigned DWIDTH_DEF   = 16;
    localparam int unsigned PWIDTH_DEF   = 24;
    localparam int unsigned SCLK_DIV_DEF = 4;
    localparam int unsigned LOG2_COLS    = $clog2(COLS_DEF);

endpackage

// File: rtl/pov_shift_out.sv
// 595-style serializer: shifts one word MSB first, then pulses latch for one clk.
module pov_shift_out
    import pov_pkg::*;
#(
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DWIDTH-1:0] word_i,
    output logic              busy_o,
    output logic              sdo_o,
    output logic              sclk_o,
    output logic              latch_o
);

    localparam int unsigned BitClks = 2 * SCLK_DIV;
    localparam int unsigned DivW    = $clog2(BitClks);
    localparam int unsigned BitW    = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    logic              busy_q, busy_d;
    logic              sdo_q, sdo_d;
    logic              sclk_q, sclk_d;
    logic              latch_q, latch_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DWIDTH-1:0] sh_q, sh_d;

    always_comb begin
        busy_d  = busy_q;
        sdo_d   = sdo_q;
        sclk_d  = sclk_q;
        latch_d = 1'b0;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (busy_q) begin
            if (div_q == DivW'(SCLK_DIV - 1)) sclk_d = 1'b1;
            if (div_q == DivW'(BitClks - 1)) begin
                div_d  = '0;
                sclk_d = 1'b0;
                if (bit_q == BitW'(DWIDTH - 1)) begin
                    // Busy drops with the latch so the next column can be accepted right away.
                    busy_d  = 1'b0;
                    latch_d = 1'b1;
                    sdo_d   = 1'b0;
                end else begin
                    bit_d = bit_q + BitW'(1);
                    sh_d  = sh_q << 1;
                    sdo_d = sh_q[DWIDTH-2];
                end
            end else begin
                div_d = div_q + DivW'(1);
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            sh_d   = word_i;
            sdo_d  = word_i[DWIDTH-1];
            sclk_d = 1'b0;
            div_d  = '0;
            bit_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            sdo_q   <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            sdo_q   <= sdo_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    assign busy_o  = busy_q;
    assign sdo_o   = sdo_q;
    assign sclk_o  = sclk_q;
    assign latch_o = latch_q;

endmodule

// File: rtl/pov_col_reader.sv
// POV column reader: measures rotation period, slices it into column ticks, streams RAM words
// to the LED chain and hands the RAM to the loader on request. POV_DIR_REV_EN reverses column order.
module pov_col_reader
    import pov_pkg::*;
#(
    parameter int unsigned COLS     = COLS_DEF,
    parameter int unsigned AWIDTH   = AWIDTH_DEF,
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned PWIDTH   = PWIDTH_DEF,
    parameter int unsigned SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              index,
    input  logic              load_req,
    output logic              load_gnt,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [DWIDTH-1:0] ram_data,
    output logic              led_sdo,
    output logic              led_sclk,
    output logic              led_latch,
    output logic              led_oe_n,
    output logic              overrun
);

    localparam int unsigned       ColShift = $clog2(COLS);
    localparam logic [PWIDTH-1:0] CntMax   = '1;
    localparam logic [AWIDTH-1:0] LastCol  = AWIDTH'(COLS - 1);

    pov_state_e        state_q, state_d;
    logic [2:0]        idx_sync_q;
    logic              idx_edge_q;
    logic [PWIDTH-1:0] cnt_q, cnt_d, period_q, period_d, timer_q, timer_d;
    logic              period_vld_q, period_vld_d;
    logic [AWIDTH-1:0] col_q, col_d, ram_addr_q, ram_addr_d;
    logic              active_q, active_d, pend_q, shown_q, shown_d, overrun_q;

    logic              sat, edge_tick, timer_tick, tick, busy, accept;
    logic [PWIDTH-1:0] step;
    logic [AWIDTH-1:0] tick_col, tick_addr;
    logic              ser_busy, ser_latch;

    always_comb begin
        sat        = (cnt_q == CntMax);
        edge_tick  = idx_edge_q && !sat && (state_q == StMeasure || state_q == StRun);
        // On an edge the fresh count is the new period, so the first timer load already uses it.
        step       = (edge_tick ? cnt_q : period_q) >> ColShift;
        if (step == '0) step = PWIDTH'(1);
        timer_tick = (state_q == StRun) && active_q && (timer_q == '0);
        tick       = edge_tick || timer_tick;
        tick_col   = edge_tick ? '0 : col_q + AWIDTH'(1);
`ifdef POV_DIR_REV_EN
        tick_addr  = LastCol - tick_col;
`else
        tick_addr  = tick_col;
`endif
        busy       = pend_q || ser_busy;
        accept     = tick && !busy && !load_req;

        state_d = state_q;
        unique case (state_q)
            StArm:     if (idx_edge_q) state_d = StMeasure;
            StMeasure: if (sat) state_d = StArm; else if (idx_edge_q) state_d = StRun;
            StRun:     if (sat) state_d = StArm;
            StGrant:   if (!load_req) state_d = period_vld_q ? StRun : StArm;
            default:   state_d = StArm;
        endcase
        if (load_req && !busy && state_q != StGrant) state_d = StGrant;

        cnt_d = idx_edge_q ? PWIDTH'(1) : (sat ? cnt_q : cnt_q + PWIDTH'(1));
        period_d     = edge_tick ? cnt_q : period_q;
        period_vld_d = sat ? 1'b0 : (edge_tick ? 1'b1 : period_vld_q);

        timer_d  = timer_q;
        col_d    = col_q;
        active_d = active_q;
        if (tick) begin
            timer_d  = step - PWIDTH'(1);
            col_d    = tick_col;
            active_d = (tick_col != LastCol);
        end else if (timer_q != '0) begin
            timer_d = timer_q - PWIDTH'(1);
        end
        // Leaving RUN (or resuming from GRANT) waits for a fresh index edge before ticking.
        if (state_d != StRun) active_d = 1'b0;

        ram_addr_d = accept ? tick_addr : ram_addr_q;
        shown_d    = (state_q != StRun) ? 1'b0 : (shown_q || ser_latch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StArm;
            idx_sync_q   <= '0;
            idx_edge_q   <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            timer_q      <= '0;
            col_q        <= '0;
            active_q     <= 1'b0;
            pend_q       <= 1'b0;
            ram_addr_q   <= '0;
            shown_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_sync_q   <= {idx_sync_q[1:0], index};
            idx_edge_q   <= idx_sync_q[1] && !idx_sync_q[2];
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            timer_q      <= timer_d;
            col_q        <= col_d;
            active_q     <= active_d;
            pend_q       <= accept;
            ram_addr_q   <= ram_addr_d;
            shown_q      <= shown_d;
            overrun_q    <= overrun_q || (tick && busy);
        end
    end

    pov_shift_out #(
        .DWIDTH  (DWIDTH),
        .SCLK_DIV(SCLK_DIV)
    ) u_shift_out (
        .clk    (clk),
        .rst    (rst),
        .start_i(pend_q),
        .word_i (ram_data),
        .busy_o (ser_busy),
        .sdo_o  (led_sdo),
        .sclk_o (led_sclk),
        .latch_o(ser_latch)
    );

    assign led_latch = ser_latch;
    assign load_gnt  = (state_q == StGrant);
    assign ram_rd    = (state_q != StGrant);
    assign led_oe_n  = !((state_q == StRun) && shown_q);
    assign ram_addr  = ram_addr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pov_col_reader.sv
// Bench for pov_col_reader: event-time reference model of ticks, drops and latches.
module tb_pov_col_reader;

    localparam int unsigned COLS = 4, AWIDTH = 8, DWIDTH = 16, PWIDTH = 12, SCLK_DIV = 2;
    localparam int BUSY_CLKS = DWIDTH * 2 * SCLK_DIV + 2;   // column busy time
    localparam int SYNC_LAT  = 3;                           // pin edge to idx_edge pulse

    logic              clk = 1'b0;
    logic              rst, index, load_req, load_gnt, ram_rd;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_data;
    logic              led_sdo, led_sclk, led_latch, led_oe_n, overrun;
    logic [DWIDTH-1:0] mem [COLS];

    int checks = 0, errors = 0, cyc = 0;

    pov_col_reader #(
        .COLS(COLS), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .PWIDTH(PWIDTH), .SCLK_DIV(SCLK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .index(index), .load_req(load_req), .load_gnt(load_gnt),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data), .led_sdo(led_sdo),
        .led_sclk(led_sclk), .led_latch(led_latch), .led_oe_n(led_oe_n), .overrun(overrun)
    );

    assign ram_data = mem[ram_addr[1:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LED chain monitor: collects shifted bits and records every latch
    logic              sclk_prev;
    logic [DWIDTH-1:0] mon_sh;
    int                mon_nb;
    logic [DWIDTH-1:0] lat_word [$];
    int                lat_cyc [$];
    int                lat_nb [$];

    always @(negedge clk) begin
        if (rst) begin
            sclk_prev = 1'b0;
            mon_sh    = '0;
            mon_nb    = 0;
        end else begin
            if (led_sclk && !sclk_prev) begin
                mon_sh = {mon_sh[DWIDTH-2:0], led_sdo};
                mon_nb++;
            end
            sclk_prev = led_sclk;
            if (led_latch) begin
                lat_word.push_back(mon_sh);
                lat_cyc.push_back(cyc);
                lat_nb.push_back(mon_nb);
                mon_nb = 0;
            end
        end
    end

    // Reference model state
    int edges [$];
    int exp_col [$];
    int exp_cyc [$];
    logic exp_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DWIDTH-1:0] exp_word(input int col);
`ifdef POV_DIR_REV_EN
        return mem[COLS-1-col];
`else
        return mem[col];
`endif
    endfunction

    // From pin-edge times: each revolution after the first is cut into COLS slots of
    // period/COLS; a slot is shown only if the previous shown slot started BUSY_CLKS ago.
    task automatic build_model();
        int last_acc;
        last_acc = -1000000;
        exp_col.delete();
        exp_cyc.delete();
        exp_ovr = 1'b0;
        for (int i = 1; i < edges.size(); i++) begin
            int e, step;
            e    = edges[i] + SYNC_LAT;
            step = (edges[i] - edges[i-1]) / COLS;
            if (step < 1) step = 1;
            for (int k = 0; k < COLS; k++) begin
                int t;
                t = e + k * step;
                if (i + 1 < edges.size() && t >= edges[i+1] + SYNC_LAT) break;
                if (t - last_acc >= BUSY_CLKS) begin
                    last_acc = t;
                    exp_col.push_back(k);
                    exp_cyc.push_back(t + BUSY_CLKS);
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_edge(input int p);
        wait_cyc(p);
        index = 1'b1;
        wait_cyc(p + 20);
        index = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        index    = 1'b0;
        load_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        lat_word.delete();
        lat_cyc.delete();
        lat_nb.delete();
        rst = 1'b0;
    endtask

    task automatic compare_run(input string tag);
        int n;
        chk({tag, "_count"}, lat_word.size(), exp_col.size());
        n = (lat_word.size() < exp_col.size()) ? lat_word.size() : exp_col.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", tag, i), lat_word[i], exp_word(exp_col[i]));
            chk($sformatf("%s_latch_cyc%0d", tag, i), lat_cyc[i], exp_cyc[i]);
            chk($sformatf("%s_sclk_edges%0d", tag, i), lat_nb[i], DWIDTH);
        end
        chk({tag, "_overrun"}, overrun, exp_ovr);
    endtask

    task automatic run_edges(input string tag);
        build_model();
        foreach (edges[i]) drive_edge(edges[i]);
        wait_cyc(edges[edges.size()-1] + 1300);
        compare_run(tag);
    endtask

    initial begin
        int p;
        mem[0] = 16'hA5A5; mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
        rst = 1'b1; index = 1'b0; load_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_rd", ram_rd, 1);
        chk("rst_load_gnt", load_gnt, 0);
        chk("rst_led_sdo", led_sdo, 0);
        chk("rst_led_sclk", led_sclk, 0);
        chk("rst_led_latch", led_latch, 0);
        chk("rst_led_oe_n", led_oe_n, 1);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Basic revolutions with the fixed pattern, plus OE and first-address checks
        p = cyc + 10;
        edges = '{p, p + 400, p + 800};
        build_model();
        drive_edge(p);
        drive_edge(p + 400);
        chk("oe_before_latch", led_oe_n, 1);
`ifdef POV_DIR_REV_EN
        chk("first_addr", ram_addr, 3);
`else
        chk("first_addr", ram_addr, 0);
`endif
        wait_cyc(p + 400 + SYNC_LAT + BUSY_CLKS + 3);
        chk("oe_after_latch", led_oe_n, 0);
        drive_edge(p + 800);
        wait_cyc(p + 2100);
        compare_run("basic");

        // Slowing rotor
        do_reset();
        p = cyc + 10;
        edges = '{p, p + 400, p + 800, p + 1500, p + 1900};
        run_edges("slow");

        // Too fast: columns dropped, overrun sticky after speed recovers
        do_reset();
        p = cyc + 10;
        edges = '{p, p + 200, p + 400, p + 600, p + 1000, p + 1400};
        run_edges("fast");

        // Random patterns and rotor speeds
        for (int r = 0; r < 4; r++) begin
            int t, n;
            do_reset();
            for (int i = 0; i < COLS; i++) mem[i] = DWIDTH'($urandom);
            edges.delete();
            t = cyc + 10;
            n = $urandom_range(3, 6);
            for (int i = 0; i < n; i++) begin
                edges.push_back(t);
                t += $urandom_range(120, 1100);
            end
            run_edges($sformatf("rand%0d", r));
        end

        // Loader grant requested mid-shift
        do_reset();
        p = cyc + 10;
        drive_edge(p);
        drive_edge(p + 400);
        wait_cyc(p + 440);
        load_req = 1'b1;
        wait_cyc(p + 403 + BUSY_CLKS);
        chk("gnt_during_latch", load_gnt, 0);
        chk("latch_before_gnt", led_latch, 1);
        wait_cyc(p + 404 + BUSY_CLKS);
        chk("gnt_after_latch", load_gnt, 1);
        chk("gnt_ram_rd", ram_rd, 0);
        chk("gnt_oe_n", led_oe_n, 1);
        wait_cyc(p + 700);
        chk("gnt_no_shift", lat_word.size(), 1);
        load_req = 1'b0;
        wait_cyc(p + 701);
        chk("release_gnt", load_gnt, 0);
        chk("release_ram_rd", ram_rd, 1);
        wait_cyc(p + 1100);
        chk("resume_waits_edge", lat_word.size(), 1);
        drive_edge(p + 1200);
        wait_cyc(p + 1500);
        chk("resume_count", lat_word.size(), 3);
        if (lat_word.size() >= 3) begin
            chk("resume_cyc0", lat_cyc[1], p + 1200 + SYNC_LAT + BUSY_CLKS);
            chk("resume_word0", lat_word[1], exp_word(0));
            chk("resume_cyc1", lat_cyc[2], p + 1200 + SYNC_LAT + 200 + BUSY_CLKS);
            chk("resume_word1", lat_word[2], exp_word(1));
        end

        // Period counter saturation drops back to ARM
        do_reset();
        p = cyc + 10;
        drive_edge(p);
        drive_edge(p + 400);
        drive_edge(p + 800);
        wait_cyc(p + 5000);
        chk("sat_oe_n", led_oe_n, 1);
        chk("sat_count", lat_word.size(), 8);
        drive_edge(p + 5100);
        wait_cyc(p + 5450);
        chk("sat_arm_no_tick", lat_word.size(), 8);
        drive_edge(p + 5500);
        wait_cyc(p + 6000);
        chk("sat_rearm_count", lat_word.size(), 12);
        chk("sat_rearm_oe_n", led_oe_n, 0);

        // Reset in the middle of a shift
        do_reset();
        p = cyc + 10;
        drive_edge(p);
        drive_edge(p + 400);
        wait_cyc(p + 440);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sdo", led_sdo, 0);
        chk("midrst_sclk", led_sclk, 0);
        chk("midrst_latch", led_latch, 0);
        chk("midrst_oe_n", led_oe_n, 1);
        repeat (60) @(posedge clk);
        #1;
        chk("midrst_no_latch", lat_word.size(), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
